kgp_risc_trace_monitor: RTL and testbench

Synthesizable, parametrised trace monitor for the KGP-RISC core. It snoops register-file write-back and records each write to a watched register into an on-chip trace FIFO. Each entry is {timestamp, register address, data}. A ready/valid port drains the FIFO. Optional filtering drops writes that do not change a register's value, and an idle watchdog flags a core that has stopped writing watched registers.

---
 rtl/kgp_risc_trace_monitor.sv | 185 ++++++++++++++++++
 tb/tb_kgp_risc_trace_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/kgp_risc_trace_monitor.sv
// Trace monitor for KGP-RISC: snoops register-file write-back into a trace FIFO
// of {timestamp, address, data}, with optional no-change filtering and an idle watchdog.
module kgp_risc_trace_monitor #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 16,
   parameter int CYCLE_W    = 16,
   parameter logic [(2**REG_ADDR_W)-1:0] WATCH_MASK = 32'h0000_007F,
   parameter int TIMEOUT    = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      clr,
   input  logic                      filter_same,
   input  logic                      wb_we,
   input  logic [REG_ADDR_W-1:0]     wb_addr,
   input  logic [DATA_W-1:0]         wb_data,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [CYCLE_W-1:0]        rd_time,
   output logic [REG_ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic [7:0]                drop_cnt,
   output logic                      stall
);

   localparam int NREG   = 2**REG_ADDR_W;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int ENT_W  = CYCLE_W + REG_ADDR_W + DATA_W;

   localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
   localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0]  IDLE_ONE = IDLE_W'(1);
   localparam logic [CYCLE_W-1:0] CYC_ONE  = CYCLE_W'(1);

   logic [DATA_W-1:0]  shadow_r [NREG];
   logic [ENT_W-1:0]   mem_r [DEPTH];
   logic [ENT_W-1:0]   head_r, head_s;
   logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [CYCLE_W-1:0] cyc_r, cyc_s;
   logic [IDLE_W-1:0]  idle_r, idle_s;
   logic [7:0]         drop_cnt_r, drop_cnt_s;
   logic               overflow_r, overflow_s;
   logic               stall_r, stall_s;
   logic               rd_valid_r, rd_valid_s;
   logic               cand_s, pop_s, push_s, drop_s, full_s;
   logic [ENT_W-1:0]   entry_s;

   // Candidate qualification against the pre-edge shadow value, plus FIFO handshake decode
   always_comb begin
      cand_s  = wb_we && en && WATCH_MASK[wb_addr] &&
                !(filter_same && (wb_data == shadow_r[wb_addr]));
      full_s  = (cnt_r == CNT_FULL);
      pop_s   = rd_valid_r && rd_ready;
      push_s  = cand_s && (!full_s || pop_s);
      drop_s  = cand_s && full_s && !pop_s;
      entry_s = {cyc_r, wb_addr, wb_data};
   end

   // Next-state for pointers, occupancy, counters and flags; clr overrides all activity
   always_comb begin
      wr_ptr_s   = wr_ptr_r;
      rd_ptr_s   = rd_ptr_r;
      cnt_s      = cnt_r;
      cyc_s      = cyc_r + CYC_ONE;
      overflow_s = overflow_r;
      drop_cnt_s = drop_cnt_r;
      idle_s     = idle_r;
      if (clr) begin
         wr_ptr_s   = {PTR_W{1'b0}};
         rd_ptr_s   = {PTR_W{1'b0}};
         cnt_s      = CNT_ZERO;
         cyc_s      = {CYCLE_W{1'b0}};
         overflow_s = 1'b0;
         drop_cnt_s = 8'd0;
         idle_s     = {IDLE_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_s = wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_s = rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_s = cnt_r - CNT_ONE;
            default: cnt_s = cnt_r;
         endcase
         overflow_s = overflow_r || drop_s;
         if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_s = drop_cnt_r + 8'd1;
         end else begin
            drop_cnt_s = drop_cnt_r;
         end
         if (!en || cand_s) begin
            idle_s = {IDLE_W{1'b0}};
         end else if (idle_r != IDLE_MAX) begin
            idle_s = idle_r + IDLE_ONE;
         end else begin
            idle_s = idle_r;
         end
      end
      stall_s    = (idle_s == IDLE_MAX);
      rd_valid_s = (cnt_s != CNT_ZERO);
   end

   // Head register lookahead: a push into an otherwise-empty slot becomes head directly
   always_comb begin
      if (cnt_s == CNT_ZERO) begin
         head_s = {ENT_W{1'b0}};
      end else if (push_s && (cnt_s == CNT_ONE)) begin
         head_s = entry_s;
      end else begin
         head_s = mem_r[rd_ptr_s];
      end
   end

   // Shadow register file tracks every write-back; untouched by clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            shadow_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_we) begin
         shadow_r[wb_addr] <= wb_data;
      end
   end

   // Trace storage; validity is tracked by the pointers, so no reset is needed
   always_ff @(posedge clk) begin
      if (push_s && !clr) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // Control and output state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         cnt_r      <= CNT_ZERO;
         cyc_r      <= {CYCLE_W{1'b0}};
         idle_r     <= {IDLE_W{1'b0}};
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         stall_r    <= 1'b0;
         rd_valid_r <= 1'b0;
         head_r     <= {ENT_W{1'b0}};
      end else begin
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         cnt_r      <= cnt_s;
         cyc_r      <= cyc_s;
         idle_r     <= idle_s;
         overflow_r <= overflow_s;
         drop_cnt_r <= drop_cnt_s;
         stall_r    <= stall_s;
         rd_valid_r <= rd_valid_s;
         head_r     <= head_s;
      end
   end

   assign rd_valid = rd_valid_r;
   assign rd_time  = head_r[ENT_W-1 -: CYCLE_W];
   assign rd_addr  = head_r[DATA_W +: REG_ADDR_W];
   assign rd_data  = head_r[DATA_W-1:0];
   assign count    = cnt_r;
   assign overflow = overflow_r;
   assign drop_cnt = drop_cnt_r;
   assign stall    = stall_r;

endmodule

// File: tb/tb_kgp_risc_trace_monitor.sv
// Scoreboard bench for kgp_risc_trace_monitor: directed writes push expected
// entries; a negedge monitor pops and compares on every accepted read.
module tb_kgp_risc_trace_monitor;

   localparam int ENT_W = 16 + 5 + 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0, clr = 1'b0, filter_same = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        rd_ready = 1'b0;
   logic        rd_valid, overflow, stall;
   logic [15:0] rd_time;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [4:0]  count;
   logic [7:0]  drop_cnt;

   logic [15:0] tb_cyc;
   logic [ENT_W-1:0] exp_q [$];
   int checks = 0;
   int failures = 0;

   kgp_risc_trace_monitor #(.TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .filter_same(filter_same),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_time(rd_time),
      .rd_addr(rd_addr), .rd_data(rd_data), .count(count),
      .overflow(overflow), .drop_cnt(drop_cnt), .stall(stall)
   );

   always #5 clk = ~clk;

   // Reference timestamp: cycles since reset or clr
   always @(posedge clk or negedge rst) begin
      if (!rst)     tb_cyc <= 16'd0;
      else if (clr) tb_cyc <= 16'd0;
      else          tb_cyc <= tb_cyc + 16'd1;
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   // Monitor: each accepted head entry is compared with the scoreboard front
   always @(negedge clk) begin
      if (rst && rd_valid && rd_ready && !clr) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_entry", 64'({rd_time, rd_addr, rd_data}), 64'h0);
            checks--;
            failures++;
            $display("FAIL extra_pop actual=entry required=none");
         end else begin
            chk("entry", 64'({rd_time, rd_addr, rd_data}), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit exp);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      if (exp) exp_q.push_back({tb_cyc, a, d});
      tick();
      wb_we = 1'b0;
   endtask

   task automatic drain(input int n);
      rd_ready = 1'b1;
      repeat (n) tick();
      rd_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset state
      #3;
      chk("rst_valid", 64'(rd_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_data", 64'({rd_time, rd_addr, rd_data}), 64'd0);
      chk("rst_flags", 64'({overflow, drop_cnt, stall}), 64'd0);
      #9 rst = 1'b1;
      en = 1'b1;

      // Stamps 3 and 4 after release; sign-extended -7
      repeat (3) tick();
      exp_q.push_back({16'd3, 5'd1, 32'd5});
      exp_q.push_back({16'd4, 5'd2, 32'hFFFF_FFF9});
      wr(5'd1, 32'd5, 1'b0);
      wr(5'd2, 32'hFFFF_FFF9, 1'b0);
      chk("basic_count", 64'(count), 64'd2);
      drain(2);
      chk("basic_drained", 64'({rd_valid, count}), 64'd0);

      // Unmasked register and filtered no-change write
      wr(5'd9, 32'd1, 1'b0);
      filter_same = 1'b1;
      wr(5'd3, 32'd0, 1'b0);
      chk("filter_none", 64'({rd_valid, count}), 64'd0);
      wr(5'd3, 32'd4, 1'b1);
      chk("filter_one", 64'(count), 64'd1);
      drain(1);
      wr(5'd3, 32'd4, 1'b0);
      chk("filter_repeat", 64'(count), 64'd0);
      filter_same = 1'b0;

      // Overflow: 17 writes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) wr(5'd4, 32'd100 + 32'(i), (i < 16));
      chk("ovf_count", 64'(count), 64'd16);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_drop", 64'(drop_cnt), 64'd1);
      chk("ovf_head", 64'({rd_addr, rd_data}), 64'({5'd4, 32'd100}));
      rd_ready = 1'b1;
      wr(5'd4, 32'd200, 1'b1);
      rd_ready = 1'b0;
      chk("full_pp_count", 64'(count), 64'd16);
      chk("full_pp_drop", 64'(drop_cnt), 64'd1);
      drain(16);
      chk("ovf_drained", 64'(count), 64'd0);

      // Watchdog after clr
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_flags", 64'({overflow, drop_cnt, stall, count}), 64'd0);
      repeat (7) tick();
      chk("stall_7", 64'(stall), 64'd0);
      tick();
      chk("stall_8", 64'(stall), 64'd1);
      wr(5'd1, 32'd77, 1'b1);
      chk("stall_clear", 64'(stall), 64'd0);
      drain(1);

      // Asynchronous reset with 5 entries held
      for (int i = 0; i < 5; i++) wr(5'd5, 32'd10 + 32'(i), 1'b1);
      chk("pre_rst_count", 64'(count), 64'd5);
      #1 rst = 1'b0;
      #1;
      chk("async_valid", 64'(rd_valid), 64'd0);
      chk("async_count", 64'(count), 64'd0);
      chk("async_data", 64'({rd_time, rd_addr, rd_data}), 64'd0);
      chk("async_flags", 64'({overflow, drop_cnt, stall}), 64'd0);
      exp_q.delete();
      #1 rst = 1'b1;
      exp_q.push_back({16'd0, 5'd1, 32'd9});
      wr(5'd1, 32'd9, 1'b0);
      drain(1);
      filter_same = 1'b1;
      wr(5'd5, 32'd0, 1'b0);
      chk("shadow_reset", 64'(count), 64'd0);
      filter_same = 1'b0;

      // clr beats a same-cycle write and pop; shadow still updates
      wr(5'd6, 32'd33, 1'b0);
      clr = 1'b1; rd_ready = 1'b1;
      wr(5'd6, 32'd55, 1'b0);
      clr = 1'b0; rd_ready = 1'b0;
      chk("clr_same_cycle", 64'({rd_valid, count, overflow}), 64'd0);
      filter_same = 1'b1;
      wr(5'd6, 32'd55, 1'b0);
      chk("clr_shadow", 64'(count), 64'd0);
      filter_same = 1'b0;

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
